button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/debounce_pkg.sv | 18 +
 rtl/sync_2ff.sv | 25 ++
 rtl/button_debounce.sv | 144 ++++++++++++++
 tb/tb_button_debounce.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and default configuration for the pushbutton debouncer.
package debounce_pkg;

  // Default consecutive synchronized samples needed to accept a level change.
  localparam int unsigned DefStableCycles = 16;
  // Default cycles spent in StHeld before the first auto-repeat strobe.
  localparam int unsigned DefRepeatDelay  = 256;
  // Default cycles between later auto-repeat strobes.
  localparam int unsigned DefRepeatPeriod = 64;

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous input into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_s1;
  logic r_s2;

  // Metastability filter: both flops clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/button_debounce.sv
// Pushbutton debouncer: synchronizes btn_in, accepts a level change only after
// STABLE_CYCLES consistent samples, and emits a one-cycle strobe per press.
// Optional auto-repeat while held is enabled by defining
// BUTTON_DEBOUNCE_AUTOREPEAT_EN; otherwise REPEAT_DELAY/REPEAT_PERIOD are unused.
// REPEAT_DELAY and REPEAT_PERIOD must be >= 2 so strobes never touch.
module button_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DefStableCycles,
  parameter int unsigned REPEAT_DELAY  = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD = DefRepeatPeriod
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level_out,
  output logic pulse_out
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  logic          w_s2;
  logic [CntW-1:0] w_cnt_inc;
  state_e        r_state;
  logic [CntW-1:0] r_cnt;
  logic          r_level;
  logic          r_pulse;

`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  localparam logic [RepW-1:0] RepDelay  = RepW'(REPEAT_DELAY);
  localparam logic [RepW-1:0] RepPeriod = RepW'(REPEAT_PERIOD);

  logic [RepW-1:0] r_rep;
  // Low while waiting out the initial delay, high once periodic repeats run.
  logic            r_rep_phase;
  logic [RepW-1:0] w_rep_inc;
  logic            w_rep_hit;

  // Repeat counter increment and target match for the current phase.
  always_comb begin
    w_rep_inc = r_rep + RepW'(1);
    w_rep_hit = (w_rep_inc == (r_rep_phase ? RepPeriod : RepDelay));
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (w_s2)
  );

  // Saturating increment so the stability counter can never wrap.
  always_comb begin
    w_cnt_inc = (r_cnt == CntMax) ? r_cnt : r_cnt + CntOne;
  end

  // Debounce FSM with registered level and strobe outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
      r_rep       <= '0;
      r_rep_phase <= 1'b0;
`endif
    end else begin
      r_pulse <= 1'b0;
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
      // Held outside StHeld at zero so every entry restarts the initial delay.
      r_rep       <= '0;
      r_rep_phase <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          if (w_s2) begin
            r_state <= StPressWait;
            r_cnt   <= CntOne;
          end
        end
        StPressWait: begin
          if (!w_s2) begin
            r_state <= StIdle;
            r_cnt   <= '0;
          end else if (r_cnt >= CntLast) begin
            r_state <= StHeld;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_pulse <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        StHeld: begin
          if (!w_s2) begin
            r_state <= StReleaseWait;
            r_cnt   <= CntOne;
          end
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
          else if (w_rep_hit) begin
            r_pulse     <= 1'b1;
            r_rep       <= '0;
            r_rep_phase <= 1'b1;
          end else begin
            r_rep       <= w_rep_inc;
            r_rep_phase <= r_rep_phase;
          end
`endif
        end
        StReleaseWait: begin
          if (w_s2) begin
            // Short release: back to held without a new strobe.
            r_state <= StHeld;
            r_cnt   <= '0;
          end else if (r_cnt >= CntLast) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_level <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign level_out = r_level;
  assign pulse_out = r_pulse;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with STABLE_CYCLES=4, REPEAT_DELAY=8,
// REPEAT_PERIOD=4. Expectations follow BUTTON_DEBOUNCE_AUTOREPEAT_EN.
module tb_button_debounce;

  logic clk;
  logic reset;
  logic btn_in;
  logic level_out;
  logic pulse_out;

  int checks   = 0;
  int failures = 0;
  int n_pulse  = 0;
  int n_level_edges = 0;
  logic prev_pulse = 1'b0;
  logic prev_level = 1'b0;
  logic [1:0] cnt2;
  int p0;
  int l0;

`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
  localparam int Rep = 1;
`else
  localparam int Rep = 0;
`endif

  button_debounce #(
    .STABLE_CYCLES (4),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .level_out (level_out),
    .pulse_out (pulse_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream 2-bit counter clocked by the falling edge of the strobe.
  always @(negedge pulse_out or posedge reset) begin
    if (reset) cnt2 <= 2'd0;
    else       cnt2 <= cnt2 + 2'd1;
  end

  // Mid-cycle monitor: counts strobes and level changes, flags back-to-back strobes.
  always @(negedge clk) begin
    if (pulse_out) n_pulse++;
    if (level_out !== prev_level) n_level_edges++;
    checks++;
    assert (!(pulse_out && prev_pulse)) else begin
      failures++;
      $error("FAIL pulse_back_to_back observed=1 expected=0");
    end
    prev_pulse = pulse_out;
    prev_level = level_out;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    btn_in = 1'b0;
    #1;
    check("rst_level", int'(level_out), 0);
    check("rst_pulse", int'(pulse_out), 0);
    tick(2);
    reset = 1'b0;
    tick(3);
    check("idle_level", int'(level_out), 0);

    // Clean press: btn high before edge 1.
    btn_in = 1'b1;
    tick(5);
    check("a_e5_level", int'(level_out), 0);
    check("a_e5_pulse", int'(pulse_out), 0);
    tick(1);
    check("a_e6_level", int'(level_out), 1);
    check("a_e6_pulse", int'(pulse_out), 1);
    tick(1);
    check("a_e7_pulse", int'(pulse_out), 0);
    check("a_e7_level", int'(level_out), 1);
    check("a_e7_cnt2", int'(cnt2), 1);

    // Short release of 2 samples while held.
    btn_in = 1'b0;
    tick(2);
    btn_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("b_short_level", int'(level_out), 1);
      check("b_short_pulse", int'(pulse_out), 0);
    end
    // Real release before edge 14: level falls after edge 19.
    btn_in = 1'b0;
    tick(5);
    check("b_e18_level", int'(level_out), 1);
    tick(1);
    check("b_e19_level", int'(level_out), 0);
    check("b_pulses", n_pulse, 1);

    // Bounce: high 2, low 1, then stable high.
    tick(2);
    p0 = n_pulse;
    l0 = n_level_edges;
    btn_in = 1'b1;
    tick(2);
    btn_in = 1'b0;
    tick(1);
    btn_in = 1'b1;
    tick(5);
    check("c_e8_level", int'(level_out), 0);
    check("c_e8_pulse", int'(pulse_out), 0);
    tick(1);
    check("c_e9_level", int'(level_out), 1);
    check("c_e9_pulse", int'(pulse_out), 1);
    tick(1);
    check("c_pulses", n_pulse - p0, 1);
    check("c_level_edges", n_level_edges - l0, 1);
    btn_in = 1'b0;
    tick(8);
    check("c_released", int'(level_out), 0);

    // Reset during press wait (cnt=2 after edge 4).
    btn_in = 1'b1;
    tick(4);
    reset = 1'b1;
    #1;
    check("d_rst_level", int'(level_out), 0);
    check("d_rst_pulse", int'(pulse_out), 0);
    tick(2);
    reset = 1'b0;
    tick(5);
    check("d_e5_pulse", int'(pulse_out), 0);
    check("d_e5_level", int'(level_out), 0);
    tick(1);
    check("d_e6_pulse", int'(pulse_out), 1);
    check("d_e6_level", int'(level_out), 1);
    // Reset in the middle of the strobe.
    reset = 1'b1;
    #1;
    check("d_midpulse_pulse", int'(pulse_out), 0);
    check("d_midpulse_level", int'(level_out), 0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("d_hold_rst_pulse", int'(pulse_out), 0);
    end
    btn_in = 1'b0;
    reset  = 1'b0;
    tick(4);
    check("d_after_level", int'(level_out), 0);

    // Clean reset so the downstream counter starts from zero.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);

    // Hold 20, release 10, press 20 again.
    p0 = n_pulse;
    btn_in = 1'b1;
    tick(6);
    check("r_first_pulse", int'(pulse_out), 1);
    tick(14);
    btn_in = 1'b0;
    tick(10);
    btn_in = 1'b1;
    tick(20);
    btn_in = 1'b0;
    tick(10);
    check("r_level_low", int'(level_out), 0);
    check("r_pulses", n_pulse - p0, (Rep != 0) ? 8 : 2);
    check("r_cnt2", int'(cnt2), (Rep != 0) ? 0 : 2);

    // Hold 30: repeats at held+8, +12, ... only with auto-repeat.
    p0 = n_pulse;
    btn_in = 1'b1;
    tick(13);
    check("e_e13_pulse", int'(pulse_out), 0);
    tick(1);
    check("e_e14_pulse", int'(pulse_out), Rep);
    tick(3);
    check("e_e17_pulse", int'(pulse_out), 0);
    tick(1);
    check("e_e18_pulse", int'(pulse_out), Rep);
    tick(12);
    check("e_e30_pulse", int'(pulse_out), Rep);
    btn_in = 1'b0;
    tick(10);
    check("e_pulses", n_pulse - p0, (Rep != 0) ? 6 : 1);
    check("e_level_low", int'(level_out), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
